// File: rtl/debug_pkg.sv
// Shared constants for the debug command receiver: opcodes, status codes,
// the default packet start marker and the receive FSM encoding.
package debug_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  localparam logic [7:0] OP_STEP   = 8'h01;
  localparam logic [7:0] OP_RUN    = 8'h02;
  localparam logic [7:0] OP_HALT   = 8'h03;
  localparam logic [7:0] OP_SET_BP = 8'h04;
  localparam logic [7:0] OP_CLR_BP = 8'h05;
  localparam logic [7:0] OP_RESET  = 8'h06;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BADCSUM = 8'hE1;
  localparam logic [7:0] ST_BADOP   = 8'hE2;
  localparam logic [7:0] ST_TIMEOUT = 8'hE3;
  localparam logic [7:0] ST_BPHIT   = 8'hB0;

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_OP     = 3'd1,
    S_ARG_HI = 3'd2,
    S_ARG_LO = 3'd3,
    S_CSUM   = 3'd4
  } rx_state_e;

  // An opcode is known when it falls in the contiguous STEP..RESET range.
  function automatic logic op_is_known(input logic [7:0] op);
    return (op >= OP_STEP) && (op <= OP_RESET);
  endfunction

endpackage

// File: rtl/debug_status_slot.sv
// Single-entry status holding register with a sticky overflow flag.
// Handshake: valid_o rises on a post and the byte in data_o is held unchanged
// until a cycle with valid_o & ready_i; a post arriving while the slot is
// occupied and not being drained that cycle is dropped and sets ovf_o.
// Port a has priority over port b when both post in the same cycle; the
// losing post always counts as dropped.
module debug_status_slot (
  input  logic       clk,
  input  logic       rst,
  input  logic       post_a_i,
  input  logic [7:0] code_a_i,
  input  logic       post_b_i,
  input  logic [7:0] code_b_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [7:0] data_o,
  output logic       ovf_o
);

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       ovf_q, ovf_d;
  logic       accept;
  logic       free;

  assign accept = valid_q & ready_i;
  assign free   = ~valid_q | accept;

  // Next-state: drain on accept, load a new post when the slot frees up,
  // otherwise record the loss.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ovf_d   = ovf_q;
    if (accept) begin
      valid_d = 1'b0;
    end
    if (post_a_i | post_b_i) begin
      if (free) begin
        valid_d = 1'b1;
        data_d  = post_a_i ? code_a_i : code_b_i;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (post_a_i & post_b_i) begin
      ovf_d = 1'b1;
    end
  end

  // Slot registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/debug_cmd_rx.sv
// Host-to-FPGA debug command receiver. Parses SYNC/op/arg_hi/arg_lo/csum
// packets from the UART byte stream, drives Z80 step/run/breakpoint/reset
// controls and posts one status byte per packet (plus timeout and breakpoint
// events) into a single-entry valid/ready status slot.
module debug_cmd_rx
  import debug_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned RST_CYCLES     = 16,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic [15:0] z80_addr,
  input  logic        z80_mem_rd,
  output logic        step_req,
  output logic [15:0] step_count,
  output logic        run,
  output logic        bp_en,
  output logic [15:0] bp_addr,
  output logic        z80_rst,
  output logic        status_valid,
  output logic [7:0]  status_data,
  input  logic        status_ready,
  output logic        status_ovf,
  output logic [2:0]  dbg_state
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  rx_state_e     state_q;
  logic [7:0]    op_q;
  logic [7:0]    arg_hi_q;
  logic [7:0]    arg_lo_q;
  logic [TW-1:0] to_cnt_q;
  logic          step_req_q;
  logic [15:0]   step_count_q;
  logic          run_q;
  logic          bp_en_q;
  logic [15:0]   bp_addr_q;
  logic          z80_rst_q;
  logic [RW-1:0] rst_cnt_q;

  logic       csum_ok;
  logic       pkt_done;
  logic       timeout_hit;
  logic       bp_hit;
  logic       cmd_post;
  logic [7:0] cmd_code;

  assign csum_ok     = (rx_data == (op_q ^ arg_hi_q ^ arg_lo_q));
  assign pkt_done    = rx_done && (state_q == S_CSUM);
  // A byte arriving on the expiry cycle wins, so rx_done masks the timeout.
  assign timeout_hit = (state_q != S_SYNC) && !rx_done && (to_cnt_q == TO_LAST);
  assign bp_hit      = run_q & bp_en_q & z80_mem_rd & (z80_addr == bp_addr_q);

  // Packet completion and timeout never coincide, so they share one post port.
  assign cmd_post = pkt_done | timeout_hit;

  // Status for the command-side post; bad checksum outranks unknown opcode.
  always_comb begin
    cmd_code = ST_OK;
    if (timeout_hit) begin
      cmd_code = ST_TIMEOUT;
    end else if (!csum_ok) begin
      cmd_code = ST_BADCSUM;
    end else if (!op_is_known(op_q)) begin
      cmd_code = ST_BADOP;
    end
  end

  // Receive FSM, inter-byte timeout, command execution and Z80 control outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_SYNC;
      op_q         <= 8'h00;
      arg_hi_q     <= 8'h00;
      arg_lo_q     <= 8'h00;
      to_cnt_q     <= '0;
      step_req_q   <= 1'b0;
      step_count_q <= 16'h0000;
      run_q        <= 1'b0;
      bp_en_q      <= 1'b0;
      bp_addr_q    <= 16'h0000;
      z80_rst_q    <= 1'b0;
      rst_cnt_q    <= '0;
    end else begin
      step_req_q <= 1'b0;

      if (rx_done || (state_q == S_SYNC) || timeout_hit) begin
        to_cnt_q <= '0;
      end else begin
        to_cnt_q <= to_cnt_q + TW'(1);
      end

      // Reset pulse countdown; a RESET command below may reload it.
      if (z80_rst_q) begin
        if (rst_cnt_q == '0) begin
          z80_rst_q <= 1'b0;
        end else begin
          rst_cnt_q <= rst_cnt_q - RW'(1);
        end
      end

      if (timeout_hit) begin
        state_q <= S_SYNC;
      end else if (rx_done) begin
        case (state_q)
          S_SYNC: begin
            if (rx_data == SYNC_BYTE) begin
              state_q <= S_OP;
            end
          end
          S_OP: begin
            op_q    <= rx_data;
            state_q <= S_ARG_HI;
          end
          S_ARG_HI: begin
            arg_hi_q <= rx_data;
            state_q  <= S_ARG_LO;
          end
          S_ARG_LO: begin
            arg_lo_q <= rx_data;
            state_q  <= S_CSUM;
          end
          S_CSUM: begin
            state_q <= S_SYNC;
            if (csum_ok) begin
              case (op_q)
                OP_STEP: begin
                  step_req_q   <= 1'b1;
                  step_count_q <= {arg_hi_q, arg_lo_q};
                end
                OP_RUN:    run_q <= 1'b1;
                OP_HALT:   run_q <= 1'b0;
                OP_SET_BP: begin
                  bp_addr_q <= {arg_hi_q, arg_lo_q};
                  bp_en_q   <= 1'b1;
                end
                OP_CLR_BP: bp_en_q <= 1'b0;
                OP_RESET: begin
                  z80_rst_q <= 1'b1;
                  rst_cnt_q <= RST_LAST;
                end
                default: ;
              endcase
            end
          end
          default: state_q <= S_SYNC;
        endcase
      end

      // Breakpoint overrides any RUN/HALT executed in the same cycle.
      if (bp_hit) begin
        run_q <= 1'b0;
      end
    end
  end

  debug_status_slot u_status (
    .clk      (clk),
    .rst      (rst),
    .post_a_i (bp_hit),
    .code_a_i (ST_BPHIT),
    .post_b_i (cmd_post),
    .code_b_i (cmd_code),
    .ready_i  (status_ready),
    .valid_o  (status_valid),
    .data_o   (status_data),
    .ovf_o    (status_ovf)
  );

  assign step_req   = step_req_q;
  assign step_count = step_count_q;
  assign run        = run_q;
  assign bp_en      = bp_en_q;
  assign bp_addr    = bp_addr_q;
  assign z80_rst    = z80_rst_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_debug_cmd_rx.sv
// Directed bench for debug_cmd_rx: packet parsing, command execution,
// breakpoint, timeout, reset pulse extension and status overflow.
module tb_debug_cmd_rx;

  localparam int unsigned TO_CYC  = 64;
  localparam int unsigned RST_CYC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [15:0] z80_addr = 16'h0000;
  logic        z80_mem_rd = 1'b0;
  logic        step_req;
  logic [15:0] step_count;
  logic        run;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic        z80_rst;
  logic        status_valid;
  logic [7:0]  status_data;
  logic        status_ready = 1'b0;
  logic        status_ovf;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  int rst_run_len  = 0;
  int rst_last_len = 0;

  debug_cmd_rx #(
    .TIMEOUT_CYCLES (TO_CYC),
    .RST_CYCLES     (RST_CYC),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .z80_addr     (z80_addr),
    .z80_mem_rd   (z80_mem_rd),
    .step_req     (step_req),
    .step_count   (step_count),
    .run          (run),
    .bp_en        (bp_en),
    .bp_addr      (bp_addr),
    .z80_rst      (z80_rst),
    .status_valid (status_valid),
    .status_data  (status_data),
    .status_ready (status_ready),
    .status_ovf   (status_ovf),
    .dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Length of the most recent contiguous z80_rst high run, sampled mid-cycle.
  always @(negedge clk) begin
    if (z80_rst) begin
      rst_run_len = rst_run_len + 1;
    end else if (rst_run_len != 0) begin
      rst_last_len = rst_run_len;
      rst_run_len  = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_pkt(input logic [7:0] op, input logic [7:0] hi,
                          input logic [7:0] lo, input logic [7:0] cs);
    send_byte(8'hA5);
    send_byte(op);
    send_byte(hi);
    send_byte(lo);
    send_byte(cs);
  endtask

  // Compare the held status with the scoreboard head, then drain it.
  task automatic pop_status(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $error("FAIL %s_sb: observed empty expected queue required non-empty", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, status_valid, 1);
      check({tag, "_data"}, status_data, e);
      status_ready = 1'b1;
      tick();
      status_ready = 1'b0;
      check({tag, "_drain"}, status_valid, 0);
    end
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    check("rst_flags", {step_req, run, bp_en, z80_rst, status_valid, status_ovf}, 6'b0);
    check("rst_step_count", step_count, 16'h0000);
    check("rst_bp_addr", bp_addr, 16'h0000);
    check("rst_status_data", status_data, 8'h00);
    check("rst_state", dbg_state, 3'd0);
    rst = 1'b1;
    tick();

    // Garbage before sync is discarded silently
    send_byte(8'h33);
    check("garbage_state", dbg_state, 3'd0);
    check("garbage_status", status_valid, 0);

    // STEP 5
    send_pkt(8'h01, 8'h00, 8'h05, 8'h04);
    exp_q.push_back(8'h00);
    check("step_req", step_req, 1);
    check("step_count", step_count, 16'h0005);
    tick();
    check("step_req_pulse", step_req, 0);
    tick();
    check("step_status_hold", status_valid, 1);
    pop_status("step");

    // SET_BP 0x1234, RUN, then breakpoint hit
    send_pkt(8'h04, 8'h12, 8'h34, 8'h22);
    exp_q.push_back(8'h00);
    check("setbp_en", bp_en, 1);
    check("setbp_addr", bp_addr, 16'h1234);
    pop_status("setbp");
    send_pkt(8'h02, 8'h00, 8'h00, 8'h02);
    exp_q.push_back(8'h00);
    check("run_set", run, 1);
    pop_status("run");
    z80_addr   = 16'h1234;
    z80_mem_rd = 1'b1;
    check("bp_run_before", run, 1);
    tick();
    z80_mem_rd = 1'b0;
    exp_q.push_back(8'hB0);
    check("bp_run_cleared", run, 0);
    pop_status("bphit");

    // Bad checksum, then unknown opcode
    send_pkt(8'h02, 8'h00, 8'h00, 8'h03);
    exp_q.push_back(8'hE1);
    check("badcsum_run", run, 0);
    pop_status("badcsum");
    send_pkt(8'h7F, 8'h00, 8'h00, 8'h7F);
    exp_q.push_back(8'hE2);
    check("badop_run", run, 0);
    check("badop_bp_en", bp_en, 1);
    check("badop_bp_addr", bp_addr, 16'h1234);
    pop_status("badop");

    // Timeout after A5 01
    send_byte(8'hA5);
    send_byte(8'h01);
    check("to_state_arg_hi", dbg_state, 3'd2);
    repeat (TO_CYC - 1) tick();
    check("to_not_yet_state", dbg_state, 3'd2);
    check("to_not_yet_status", status_valid, 0);
    tick();
    exp_q.push_back(8'hE3);
    check("to_state_sync", dbg_state, 3'd0);
    pop_status("timeout");
    send_pkt(8'h01, 8'h00, 8'h00, 8'h01);
    exp_q.push_back(8'h00);
    check("to_then_step_req", step_req, 1);
    check("to_then_step_zero", step_count, 16'h0000);
    pop_status("after_to");

    // A byte on the expiry cycle wins over the timeout
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TO_CYC - 1) tick();
    send_byte(8'h00);
    check("to_race_state", dbg_state, 3'd3);
    check("to_race_status", status_valid, 0);
    send_byte(8'h07);
    send_byte(8'h06);
    exp_q.push_back(8'h00);
    check("to_race_step_req", step_req, 1);
    check("to_race_step_count", step_count, 16'h0007);
    pop_status("to_race");

    // RESET twice, second completing 5 cycles after the first
    status_ready = 1'b1;
    send_pkt(8'h06, 8'h00, 8'h00, 8'h06);
    check("zrst_high", z80_rst, 1);
    send_pkt(8'h06, 8'h00, 8'h00, 8'h06);
    check("zrst_still_high", z80_rst, 1);
    repeat (30) tick();
    check("zrst_len", rst_last_len, RST_CYC + 5);
    check("zrst_low", z80_rst, 0);
    check("zrst_run_unchanged", run, 0);
    status_ready = 1'b0;
    check("zrst_status_drained", status_valid, 0);
    check("zrst_no_ovf", status_ovf, 0);

    // Overflow: two posts with ready held low
    send_pkt(8'h01, 8'h00, 8'h02, 8'h03);
    check("ovf_first_valid", status_valid, 1);
    check("ovf_first_step", step_count, 16'h0002);
    send_pkt(8'h7F, 8'h00, 8'h00, 8'h7F);
    check("ovf_kept_data", status_data, 8'h00);
    check("ovf_flag", status_ovf, 1);

    // Mid-packet asynchronous reset
    send_byte(8'hA5);
    send_byte(8'h01);
    rst = 1'b0;
    #1;
    check("mid_rst_flags", {step_req, run, bp_en, z80_rst, status_valid, status_ovf}, 6'b0);
    check("mid_rst_step_count", step_count, 16'h0000);
    check("mid_rst_bp_addr", bp_addr, 16'h0000);
    check("mid_rst_status_data", status_data, 8'h00);
    check("mid_rst_state", dbg_state, 3'd0);
    tick();
    rst = 1'b1;
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h02);
    check("post_rst_state", dbg_state, 3'd0);
    check("post_rst_status", status_valid, 0);
    check("post_rst_step", step_req, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
